// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment (hazard unit, EX redirect,
// instruction memory, and the IF/ID consumer).
interface fetch_stage_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rd_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic        ifid_valid_o;
    logic [31:0] fetch_count_o;

    modport master (
        input  stall_i, redirect_i, target_i, imem_rd_i,
        output imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus4_o,
        output ifid_valid_o, fetch_count_o
    );

    modport slave (
        output stall_i, redirect_i, target_i, imem_rd_i,
        input  imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus4_o,
        input  ifid_valid_o, fetch_count_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and accepted-fetch counter.
// One BOOT cycle after reset fetches RESET_PC but inserts a bubble before normal operation.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_instr, w_instr_next;
    logic [31:0] r_ifid_pc, w_ifid_pc_next;
    logic [31:0] r_ifid_pc4, w_ifid_pc4_next;
    logic        r_valid, w_valid_next;
    logic [31:0] r_count, w_count_next;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_ifid_pc_next  = r_ifid_pc;
        w_ifid_pc4_next = r_ifid_pc4;
        w_valid_next    = r_valid;
        w_count_next    = r_count;
        case (r_state)
            ST_BOOT: begin
                // PC stays on RESET_PC so the first real fetch happens in RUN.
                w_state_next    = ST_RUN;
                w_instr_next    = NOP_INSTR;
                w_ifid_pc_next  = 32'd0;
                w_ifid_pc4_next = 32'd0;
                w_valid_next    = 1'b0;
            end
            default: begin
                if (bus.redirect_i) begin
                    w_pc_next       = {bus.target_i[31:2], 2'b00};
                    w_instr_next    = NOP_INSTR;
                    w_ifid_pc_next  = 32'd0;
                    w_ifid_pc4_next = 32'd0;
                    w_valid_next    = 1'b0;
                end else if (!bus.stall_i) begin
                    w_pc_next       = w_pc_plus4;
                    w_instr_next    = bus.imem_rd_i;
                    w_ifid_pc_next  = r_pc;
                    w_ifid_pc4_next = w_pc_plus4;
                    w_valid_next    = 1'b1;
                    w_count_next    = r_count + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_ifid_pc  <= 32'd0;
            r_ifid_pc4 <= 32'd0;
            r_valid    <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_ifid_pc  <= w_ifid_pc_next;
            r_ifid_pc4 <= w_ifid_pc4_next;
            r_valid    <= w_valid_next;
            r_count    <= w_count_next;
        end
    end

    assign bus.imem_addr_o     = r_pc;
    assign bus.ifid_instr_o    = r_instr;
    assign bus.ifid_pc_o       = r_ifid_pc;
    assign bus.ifid_pc_plus4_o = r_ifid_pc4;
    assign bus.ifid_valid_o    = r_valid;
    assign bus.fetch_count_o   = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default-parameter instance plus a RESET_PC=FFFFFFFC
// instance for the PC wrap case, both fed from one small combinational memory.
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [31:0] mem [0:15];

    fetch_stage_if f0 ();
    fetch_stage_if f1 ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut0 (
        .clk(clk), .rst(rst), .bus(f0.master)
    );
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_dut1 (
        .clk(clk), .rst(rst), .bus(f1.master)
    );

    assign f0.imem_rd_i = mem[f0.imem_addr_o[5:2]];
    assign f1.imem_rd_i = mem[f1.imem_addr_o[5:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic valid, input logic [31:0] cnt,
                            input logic [31:0] addr);
        chk({tag, ".instr"}, f0.ifid_instr_o, instr);
        chk({tag, ".pc"},    f0.ifid_pc_o, pc);
        chk({tag, ".pc4"},   f0.ifid_pc_plus4_o, pc4);
        chk({tag, ".valid"}, {31'd0, f0.ifid_valid_o}, {31'd0, valid});
        chk({tag, ".count"}, f0.fetch_count_o, cnt);
        chk({tag, ".addr"},  f0.imem_addr_o, addr);
        $display("step %s: addr=%h instr=%h pc=%h valid=%0d count=%0d", tag,
                 f0.imem_addr_o, f0.ifid_instr_o, f0.ifid_pc_o, f0.ifid_valid_o, f0.fetch_count_o);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;
        mem[0]  = 32'hFFC4A303;
        mem[1]  = 32'h0064A423;
        mem[2]  = 32'h0062E233;
        mem[3]  = 32'hFE420AE3;
        mem[15] = 32'h00100093;

        rst = 1'b1;
        f0.stall_i = 1'b0; f0.redirect_i = 1'b0; f0.target_i = 32'd0;
        f1.stall_i = 1'b0; f1.redirect_i = 1'b0; f1.target_i = 32'd0;
        step();
        step();
        chk_ifid("reset", 32'h13, 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
        chk("reset.f1addr", f1.imem_addr_o, 32'hFFFF_FFFC);

        // Free run from reset: one bubble, then the four words in order.
        rst = 1'b0;
        step();
        chk_ifid("boot", 32'h13, 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
        chk("boot.f1valid", {31'd0, f1.ifid_valid_o}, 32'd0);
        chk("boot.f1addr", f1.imem_addr_o, 32'hFFFF_FFFC);
        step();
        chk_ifid("run1", 32'hFFC4A303, 32'h0, 32'h4, 1'b1, 32'd1, 32'h4);
        chk("wrap1.pc", f1.ifid_pc_o, 32'hFFFF_FFFC);
        chk("wrap1.pc4", f1.ifid_pc_plus4_o, 32'h0);
        chk("wrap1.instr", f1.ifid_instr_o, 32'h00100093);
        chk("wrap1.addr", f1.imem_addr_o, 32'h0);
        step();
        chk_ifid("run2", 32'h0064A423, 32'h4, 32'h8, 1'b1, 32'd2, 32'h8);
        chk("wrap2.pc", f1.ifid_pc_o, 32'h0);
        chk("wrap2.instr", f1.ifid_instr_o, 32'hFFC4A303);

        // Three-cycle stall holds everything.
        f0.stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_ifid("stall", 32'h0064A423, 32'h4, 32'h8, 1'b1, 32'd2, 32'h8);
        end
        f0.stall_i = 1'b0;
        step();
        chk_ifid("resume", 32'h0062E233, 32'h8, 32'hC, 1'b1, 32'd3, 32'hC);
        step();
        chk_ifid("run4", 32'hFE420AE3, 32'hC, 32'h10, 1'b1, 32'd4, 32'h10);

        // Redirect from PC=0x10 back to 0.
        f0.redirect_i = 1'b1; f0.target_i = 32'h0;
        step();
        chk_ifid("redir", 32'h13, 32'h0, 32'h0, 1'b0, 32'd4, 32'h0);
        f0.redirect_i = 1'b0;
        step();
        chk_ifid("postredir", 32'hFFC4A303, 32'h0, 32'h4, 1'b1, 32'd5, 32'h4);
        step();
        chk_ifid("run6", 32'h0064A423, 32'h4, 32'h8, 1'b1, 32'd6, 32'h8);

        // Redirect beats stall; target low bits dropped.
        f0.redirect_i = 1'b1; f0.stall_i = 1'b1; f0.target_i = 32'h7;
        step();
        chk_ifid("redirstall", 32'h13, 32'h0, 32'h0, 1'b0, 32'd6, 32'h4);
        f0.redirect_i = 1'b0; f0.stall_i = 1'b0; f0.target_i = 32'h0;
        step();
        chk_ifid("run7", 32'h0064A423, 32'h4, 32'h8, 1'b1, 32'd7, 32'h8);

        // Reset asserted during a stall.
        f0.stall_i = 1'b1;
        step();
        chk_ifid("prerst", 32'h0064A423, 32'h4, 32'h8, 1'b1, 32'd7, 32'h8);
        rst = 1'b1;
        step();
        chk_ifid("rststall", 32'h13, 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
        chk("rststall.f1addr", f1.imem_addr_o, 32'hFFFF_FFFC);

        // BOOT ignores both stall and redirect.
        rst = 1'b0; f0.redirect_i = 1'b1; f0.target_i = 32'h40;
        step();
        chk_ifid("bootign", 32'h13, 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
        f0.redirect_i = 1'b0; f0.stall_i = 1'b0;
        step();
        chk_ifid("run1b", 32'hFFC4A303, 32'h0, 32'h4, 1'b1, 32'd1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
